// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//
// Conditions raw pad inputs (SB_IO D_IN_0) before they reach the SoC pin
// consumers (pin interrupts, quadrature, pulse-in). Each pin goes through
// these steps:
//   1. A two-flop synchroniser.
//   2. A per-pin debouncer. A new level is accepted only after it has been
//      seen at the synchroniser output for DEBOUNCE_CYCLES consecutive cycles.
//   3. Registered one-cycle rise/fall pulses. These line up with the first
//      cycle in which the clean level changes.
//   4. Sticky rise/fall event flags with a per-pin clear. If a set and a
//      clear land in the same cycle, the set wins.
//
// Ports
//   io_mainClk      in   1      single clock, all state on its rising edge
//   io_asyncResetn  in   1      asynchronous active-low reset (all state to 0)
//   io_pins_raw     in   WIDTH  raw pad levels, asynchronous to io_mainClk
//   io_evt_clear    in   WIDTH  per-pin clear of both sticky flags
//   io_pins_clean   out  WIDTH  debounced level per pin
//   io_pins_rise    out  WIDTH  one-cycle pulse per accepted 0->1
//   io_pins_fall    out  WIDTH  one-cycle pulse per accepted 1->0
//   io_evt_rise     out  WIDTH  sticky rise-event flags
//   io_evt_fall     out  WIDTH  sticky fall-event flags
//
// Parameters
//   WIDTH            number of conditioned pins
//   DEBOUNCE_CYCLES  1..65535. Number of cycles a new level must persist.
//   CNT_W            counter width. Requires 2**CNT_W > DEBOUNCE_CYCLES.
module gpio_in_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             io_mainClk,
  input  logic             io_asyncResetn,
  input  logic [WIDTH-1:0] io_pins_raw,
  output logic [WIDTH-1:0] io_pins_clean,
  output logic [WIDTH-1:0] io_pins_rise,
  output logic [WIDTH-1:0] io_pins_fall,
  output logic [WIDTH-1:0] io_evt_rise,
  output logic [WIDTH-1:0] io_evt_fall,
  input  logic [WIDTH-1:0] io_evt_clear
);

  // Terminal count. Acceptance happens on the edge where the counter already
  // sits at this value and the level still differs.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Saturating debounce step. The counter restarts whenever the level agrees
  // with the accepted one. It also restarts on the acceptance edge itself, so
  // it never exceeds CNT_MAX and never wraps.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                 input logic             differ);
    if (!differ || (cnt == CNT_MAX))
      return '0;
    else
      return cnt + CNT_W'(1);
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic             sync1_p0;
    logic             sync2_p1;
    logic             stable_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic             rise_p2;
    logic             fall_p2;
    logic             evt_rise_p3;
    logic             evt_fall_p3;
    logic             differ;
    logic             accept;

    assign differ = (sync2_p1 != stable_p2);
    assign accept = differ && (cnt_p2 == CNT_MAX);

    // Stage p0/p1: two-flop synchroniser. Only sync2_p1 feeds the debouncer.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        sync1_p0 <= 1'b0;
        sync2_p1 <= 1'b0;
      end else begin
        sync1_p0 <= io_pins_raw[i];
        sync2_p1 <= sync1_p0;
      end
    end

    // Stage p2: debounce counter, accepted level and the edge pulses. The
    // pulses are registered alongside stable_p2, so they coincide with the
    // first cycle of the new clean level.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        cnt_p2    <= '0;
        stable_p2 <= 1'b0;
        rise_p2   <= 1'b0;
        fall_p2   <= 1'b0;
      end else begin
        cnt_p2  <= cnt_step(cnt_p2, differ);
        rise_p2 <= accept &&  sync2_p1;
        fall_p2 <= accept && !sync2_p1;
        if (accept)
          stable_p2 <= sync2_p1;
      end
    end

    // Stage p3: sticky event flags, set one cycle after the pulse.
    // The set term is ORed in after the clear term, so the set wins.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        evt_rise_p3 <= 1'b0;
        evt_fall_p3 <= 1'b0;
      end else begin
        evt_rise_p3 <= rise_p2 | (evt_rise_p3 & ~io_evt_clear[i]);
        evt_fall_p3 <= fall_p2 | (evt_fall_p3 & ~io_evt_clear[i]);
      end
    end

    assign io_pins_clean[i] = stable_p2;
    assign io_pins_rise[i]  = rise_p2;
    assign io_pins_fall[i]  = fall_p2;
    assign io_evt_rise[i]   = evt_rise_p3;
    assign io_evt_fall[i]   = evt_fall_p3;
  end

endmodule
